// File: rtl/mem_arbiter_if.sv
// Bundles the IFU, LSU and memory-side signals of the memory arbiter.
// master: the arbiter's own view. slave: the environment (requesters plus memory).
// Pure wiring, no logic.
interface mem_arbiter_if;
    // IFU request/response
    logic        ifu_req;
    logic [31:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        ifu_err;
    // LSU request/response
    logic        lsu_req;
    logic        lsu_we;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic        lsu_bvalid;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    // memory request/response
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_bvalid;

    modport master (
        input  ifu_req, ifu_addr,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        input  mem_ready, mem_rvalid, mem_rdata, mem_bvalid,
        output ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        output lsu_gnt, lsu_rvalid, lsu_bvalid, lsu_rdata, lsu_err,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        output ifu_req, ifu_addr,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
        output mem_ready, mem_rvalid, mem_rdata, mem_bvalid,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, ifu_err,
        input  lsu_gnt, lsu_rvalid, lsu_bvalid, lsu_rdata, lsu_err,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (reads) and LSU (reads/writes).
// Latency: gnt 1 cycle after the req edge, response 3 cycles after it at best; abort after TIMEOUT_CYC cycles.
// Backpressure: mem_valid and its payload hold until mem_ready; requests are sampled only while idle.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
    typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_t;

    localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYC);

    state_t      state, state_nxt;
    owner_t      owner, owner_nxt;
    owner_t      last_owner, last_owner_nxt;
    logic [15:0] cnt, cnt_nxt;

    logic        mem_valid_q, mem_valid_nxt;
    logic        mem_we_q, mem_we_nxt;
    logic [31:0] mem_addr_q, mem_addr_nxt;
    logic [31:0] mem_wdata_q, mem_wdata_nxt;
    logic [3:0]  mem_wmask_q, mem_wmask_nxt;
    logic        ifu_gnt_q, ifu_gnt_nxt;
    logic        ifu_rvalid_q, ifu_rvalid_nxt;
    logic        ifu_err_q, ifu_err_nxt;
    logic [31:0] ifu_rdata_q, ifu_rdata_nxt;
    logic        lsu_gnt_q, lsu_gnt_nxt;
    logic        lsu_rvalid_q, lsu_rvalid_nxt;
    logic        lsu_bvalid_q, lsu_bvalid_nxt;
    logic        lsu_err_q, lsu_err_nxt;
    logic [31:0] lsu_rdata_q, lsu_rdata_nxt;

    logic        pick_lsu;
    logic        tmo_hit;
    logic        done;
    logic        tmo_abort;

    // State register plus every registered output; reset clears all and hands the next tie to IFU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= OWN_IFU;
            last_owner   <= OWN_LSU;
            cnt          <= 16'd0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wmask_q  <= 4'd0;
            ifu_gnt_q    <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            ifu_err_q    <= 1'b0;
            ifu_rdata_q  <= 32'd0;
            lsu_gnt_q    <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            lsu_bvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= 32'd0;
        end else begin
            state        <= state_nxt;
            owner        <= owner_nxt;
            last_owner   <= last_owner_nxt;
            cnt          <= cnt_nxt;
            mem_valid_q  <= mem_valid_nxt;
            mem_we_q     <= mem_we_nxt;
            mem_addr_q   <= mem_addr_nxt;
            mem_wdata_q  <= mem_wdata_nxt;
            mem_wmask_q  <= mem_wmask_nxt;
            ifu_gnt_q    <= ifu_gnt_nxt;
            ifu_rvalid_q <= ifu_rvalid_nxt;
            ifu_err_q    <= ifu_err_nxt;
            ifu_rdata_q  <= ifu_rdata_nxt;
            lsu_gnt_q    <= lsu_gnt_nxt;
            lsu_rvalid_q <= lsu_rvalid_nxt;
            lsu_bvalid_q <= lsu_bvalid_nxt;
            lsu_err_q    <= lsu_err_nxt;
            lsu_rdata_q  <= lsu_rdata_nxt;
        end
    end

    // Next-state and next-output logic: arbitrate in IDLE, hold the request in ISSUE, await the response.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        cnt_nxt        = cnt;
        mem_valid_nxt  = 1'b0;
        mem_we_nxt     = mem_we_q;
        mem_addr_nxt   = mem_addr_q;
        mem_wdata_nxt  = mem_wdata_q;
        mem_wmask_nxt  = mem_wmask_q;
        ifu_gnt_nxt    = 1'b0;
        ifu_rvalid_nxt = 1'b0;
        ifu_err_nxt    = 1'b0;
        ifu_rdata_nxt  = ifu_rdata_q;
        lsu_gnt_nxt    = 1'b0;
        lsu_rvalid_nxt = 1'b0;
        lsu_bvalid_nxt = 1'b0;
        lsu_err_nxt    = 1'b0;
        lsu_rdata_nxt  = lsu_rdata_q;
        // LSU wins when alone, or on a tie when IFU owned the previous transaction.
        pick_lsu       = bus.lsu_req && (!bus.ifu_req || last_owner == OWN_IFU);
        tmo_hit        = (cnt + 16'd1) == TMO_LIM;
        done           = 1'b0;
        tmo_abort      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.ifu_req || bus.lsu_req) begin
                    state_nxt     = ISSUE;
                    cnt_nxt       = 16'd0;
                    mem_valid_nxt = 1'b1;
                    if (pick_lsu) begin
                        owner_nxt     = OWN_LSU;
                        lsu_gnt_nxt   = 1'b1;
                        mem_we_nxt    = bus.lsu_we;
                        mem_addr_nxt  = bus.lsu_addr;
                        mem_wdata_nxt = bus.lsu_wdata;
                        mem_wmask_nxt = bus.lsu_wmask;
                    end else begin
                        owner_nxt     = OWN_IFU;
                        ifu_gnt_nxt   = 1'b1;
                        mem_we_nxt    = 1'b0;
                        mem_addr_nxt  = bus.ifu_addr;
                        mem_wdata_nxt = 32'd0;
                        mem_wmask_nxt = 4'd0;
                    end
                end
            end
            ISSUE: begin
                cnt_nxt = cnt + 16'd1;
                // Timeout beats a coincident mem_ready: the transaction is already given up.
                if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end else if (bus.mem_ready) begin
                    state_nxt = WAIT_RESP;
                end else begin
                    mem_valid_nxt = 1'b1;
                end
            end
            WAIT_RESP: begin
                cnt_nxt = cnt + 16'd1;
                // Only the response type matching the operation counts; completion beats timeout.
                if (mem_we_q ? bus.mem_bvalid : bus.mem_rvalid) begin
                    done = 1'b1;
                end else if (tmo_hit) begin
                    tmo_abort = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (done || tmo_abort) begin
            state_nxt      = IDLE;
            last_owner_nxt = owner;
            if (owner == OWN_IFU) begin
                ifu_rvalid_nxt = 1'b1;
                ifu_err_nxt    = tmo_abort;
                ifu_rdata_nxt  = tmo_abort ? 32'd0 : bus.mem_rdata;
            end else if (mem_we_q) begin
                lsu_bvalid_nxt = 1'b1;
                lsu_err_nxt    = tmo_abort;
                if (tmo_abort) begin
                    lsu_rdata_nxt = 32'd0;
                end
            end else begin
                lsu_rvalid_nxt = 1'b1;
                lsu_err_nxt    = tmo_abort;
                lsu_rdata_nxt  = tmo_abort ? 32'd0 : bus.mem_rdata;
            end
        end
    end

    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wmask  = mem_wmask_q;
    assign bus.ifu_gnt    = ifu_gnt_q;
    assign bus.ifu_rvalid = ifu_rvalid_q;
    assign bus.ifu_err    = ifu_err_q;
    assign bus.ifu_rdata  = ifu_rdata_q;
    assign bus.lsu_gnt    = lsu_gnt_q;
    assign bus.lsu_rvalid = lsu_rvalid_q;
    assign bus.lsu_bvalid = lsu_bvalid_q;
    assign bus.lsu_err    = lsu_err_q;
    assign bus.lsu_rdata  = lsu_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level timeline model.
// Each transaction's gnt, mem_valid window and response cycle are derived arithmetically.
// Memory side is scripted per transaction (ready delay, response delay, stray pulses).
module tb_mem_arbiter;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    bit          last_lsu;
    logic [31:0] exp_ird;
    logic [31:0] exp_lrd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_out(input bit gi, input bit gl, input bit mv, input bit rvi,
                           input bit rvl, input bit bv, input bit ei, input bit el);
        chk("ifu_gnt", bus.ifu_gnt, gi);
        chk("lsu_gnt", bus.lsu_gnt, gl);
        chk("mem_valid", bus.mem_valid, mv);
        chk("ifu_rvalid", bus.ifu_rvalid, rvi);
        chk("lsu_rvalid", bus.lsu_rvalid, rvl);
        chk("lsu_bvalid", bus.lsu_bvalid, bv);
        chk("ifu_err", bus.ifu_err, ei);
        chk("lsu_err", bus.lsu_err, el);
        chk("ifu_rdata", bus.ifu_rdata, exp_ird);
        chk("lsu_rdata", bus.lsu_rdata, exp_lrd);
    endtask

    task automatic chk_reset(input string tag);
        exp_ird  = 32'd0;
        exp_lrd  = 32'd0;
        last_lsu = 1'b1;
        chk_out(0, 0, 0, 0, 0, 0, 0, 0);
        chk({tag, "_mem_we"}, bus.mem_we, 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_mem_wmask"}, bus.mem_wmask, 32'd0);
    endtask

    task automatic drive_zero();
        bus.ifu_req    = 1'b0;
        bus.ifu_addr   = $urandom;
        bus.lsu_req    = 1'b0;
        bus.lsu_we     = 1'b0;
        bus.lsu_addr   = $urandom;
        bus.lsu_wdata  = $urandom;
        bus.lsu_wmask  = 4'($urandom);
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_bvalid = 1'b0;
        bus.mem_rdata  = $urandom;
    endtask

    // Idle cycles; with stray set, both memory response strobes pulse in the first one.
    task automatic idle_cycles(input int n, input bit stray);
        for (int k = 0; k < n; k++) begin
            drive_zero();
            bus.mem_rvalid = stray && (k == 0);
            bus.mem_bvalid = stray && (k == 0);
            @(negedge clk);
            chk_out(0, 0, 0, 0, 0, 0, 0, 0);
            @(posedge clk);
            #1;
        end
    endtask

    // Cycle k=0 carries the request (sampled at edge 0); cycle k is the interval after edge k-1.
    task automatic run_txn(input bit ir, input bit lr, input logic [31:0] ia, input logic [31:0] la,
                           input bit we, input logic [31:0] wd, input logic [3:0] wm,
                           input int d, input bit rdy_en, input int r, input logic [31:0] rd,
                           input bit hold_i, input bit hold_l, input int gap, input bit stray);
        bit          win_lsu, wr, ab, resp;
        int          e, rc, mv_end, last;
        logic [31:0] x_addr, x_wd;
        logic [3:0]  x_wm;
        win_lsu = lr && (!ir || !last_lsu);
        wr      = win_lsu && we;
        e       = 2 + d + r;                      // edge at which the response strobe is sampled
        ab      = !rdy_en || (e > T);
        rc      = ab ? T + 1 : e + 1;             // cycle in which the requester sees its response
        mv_end  = (rdy_en && (1 + d < T)) ? 1 + d : T;
        last    = (rdy_en && e > rc) ? e : rc;
        x_addr  = win_lsu ? la : ia;
        x_wd    = win_lsu ? wd : 32'd0;
        x_wm    = win_lsu ? wm : 4'd0;
        for (int k = 0; k <= last; k++) begin
            bus.ifu_req    = ir && (k == 0 || (hold_i && k < rc));
            bus.lsu_req    = lr && (k == 0 || (hold_l && k < rc));
            bus.ifu_addr   = (k == 0) ? ia : $urandom;
            bus.lsu_addr   = (k == 0) ? la : $urandom;
            bus.lsu_we     = (k == 0) ? we : 1'($urandom);
            bus.lsu_wdata  = (k == 0) ? wd : $urandom;
            bus.lsu_wmask  = (k == 0) ? wm : 4'($urandom);
            bus.mem_ready  = rdy_en && (k == 1 + d);
            bus.mem_rvalid = rdy_en && ((!wr && k == e) || (wr && r > 0 && k == 2 + d));
            bus.mem_bvalid = rdy_en && ((wr && k == e) || (!wr && r > 0 && k == 2 + d));
            bus.mem_rdata  = (k == e) ? rd : $urandom;
            if (k == rc) begin
                if (!win_lsu)  exp_ird = ab ? 32'd0 : rd;
                else if (!wr)  exp_lrd = ab ? 32'd0 : rd;
                else if (ab)   exp_lrd = 32'd0;
            end
            @(negedge clk);
            if (k >= 1) begin
                resp = (k == rc);
                chk_out(!win_lsu && k == 1, win_lsu && k == 1, k <= mv_end,
                        resp && !win_lsu, resp && win_lsu && !wr, resp && wr,
                        resp && ab && !win_lsu, resp && ab && win_lsu);
                if (k <= mv_end) begin
                    chk("mem_we", bus.mem_we, wr);
                    chk("mem_addr", bus.mem_addr, x_addr);
                    chk("mem_wdata", bus.mem_wdata, x_wd);
                    chk("mem_wmask", bus.mem_wmask, x_wm);
                end
            end
            @(posedge clk);
            #1;
        end
        last_lsu = win_lsu;
        idle_cycles(gap, stray);
    endtask

    int sel;
    int gap;

    initial begin
        rst = 1'b1;
        drive_zero();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("rst");
        rst = 1'b0;

        // Ties straight out of reset: IFU first, then LSU.
        run_txn(1, 1, 32'h0000_1000, 32'h0000_2000, 1'b0, 32'h1111_1111, 4'h3,
                0, 1, 0, 32'hA5A5_0001, 1, 1, 0, 0);
        run_txn(1, 1, 32'h0000_1004, 32'h0000_2004, 1'b1, 32'h2222_2222, 4'hC,
                1, 1, 1, 32'hA5A5_0002, 1, 1, 0, 0);
        // Minimum-latency IFU read.
        run_txn(1, 0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0,
                0, 1, 0, 32'h0000_0413, 0, 0, 1, 0);
        // LSU write with mem_ready held off four cycles.
        run_txn(0, 1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF,
                4, 1, 1, 32'h0, 0, 0, 1, 0);
        // Timeout: memory never accepts.
        run_txn(1, 0, 32'h8000_0010, 32'h0, 1'b0, 32'h0, 4'h0,
                0, 0, 0, 32'h0, 0, 0, 1, 0);
        // Stray responses while idle.
        idle_cycles(3, 1);

        // Reset in the middle of WAIT_RESP, followed by a late mem_rvalid.
        drive_zero();
        bus.ifu_req  = 1'b1;
        bus.ifu_addr = 32'h8000_0040;
        @(posedge clk);
        #1;
        bus.ifu_req   = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        @(posedge clk);
        #1;
        chk_reset("rst_hold");
        rst = 1'b0;
        idle_cycles(3, 1);
        // First tie after reset goes to IFU again.
        run_txn(1, 1, 32'h0000_3000, 32'h0000_4000, 1'b0, 32'h0, 4'h0,
                0, 1, 0, 32'h1234_5678, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(1, 3);
            gap = $urandom_range(0, 3);
            run_txn(sel[0], sel[1], $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                    4'($urandom), $urandom_range(0, 8), $urandom_range(0, 9) != 0,
                    $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), gap, (gap >= 2) && ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
